// File: rtl/alu_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_seq_pkg
// Brief    : Opcodes, FSM state encoding and helpers shared by the alu_seq block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_WORD  = 4'b0110;
    localparam logic [3:0] OP_LUI   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic op_is_iter(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
//------------------------------------------------------------------------------
// Module   : alu_seq_if
// Brief    : Request/response bundle between the control unit and alu_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, A, B,
        input  ready, done, result, zero, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, A, B,
        output ready, done, result, zero, hi, lo, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
//------------------------------------------------------------------------------
// Module   : alu_seq_muldiv
// Brief    : Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             go_i,
    input  wire logic             op_div_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    output logic                  fin_o,
    output logic                  dbz_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o
);
    localparam int CW = $clog2(WIDTH);

    logic               run_q;
    logic               div_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] p_d;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_tmp;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;

    // p_q is {hi, lo}: product accumulates in hi while the multiplier shifts out
    // of lo; for divide, hi is the partial remainder and lo collects quotient bits.
    always_comb begin
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
        div_tmp = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_ge  = (div_tmp >= {1'b0, opnd_q});
        div_sub = div_tmp[WIDTH-1:0] - opnd_q;
        if (div_q) begin
            p_d = {(div_ge ? div_sub : div_tmp[WIDTH-1:0]), p_q[WIDTH-2:0], div_ge};
        end else begin
            p_d = {mul_sum, p_q[WIDTH-1:1]};
        end
    end

    assign fin_o = run_q && (cnt_q == CW'(WIDTH - 1));
    assign dbz_o = op_div_i && (b_i == '0);
    assign hi_o  = p_d[2*WIDTH-1:WIDTH];
    assign lo_o  = p_d[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q  <= 1'b0;
            div_q  <= 1'b0;
            opnd_q <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
        end else if (go_i) begin
            run_q  <= !dbz_o;
            div_q  <= op_div_i;
            opnd_q <= op_div_i ? b_i : a_i;
            p_q    <= {{WIDTH{1'b0}}, (op_div_i ? a_i : b_i)};
            cnt_q  <= '0;
        end else if (run_q) begin
            p_q   <= p_d;
            cnt_q <= cnt_q + 1'b1;
            if (fin_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// Module   : alu_seq
// Brief    : Multi-cycle ALU: registered single-cycle ops plus iterative MULTU/DIVU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic [WIDTH-1:0] alu_y;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;

    logic             md_fin;
    logic             md_dbz;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign accept = (state_q == S_IDLE) && bus.start;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .go_i     (accept && op_is_iter(bus.op)),
        .op_div_i (bus.op == OP_DIVU),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .fin_o    (md_fin),
        .dbz_o    (md_dbz),
        .hi_o     (md_hi),
        .lo_o     (md_lo)
    );

    always_comb begin
        alu_y = '0;
        case (bus.op)
            OP_AND:           alu_y = bus.A & bus.B;
            OP_OR:            alu_y = bus.A | bus.B;
            OP_NOR:           alu_y = ~(bus.A | bus.B);
            OP_ADD, OP_WORD:  alu_y = bus.A + bus.B;
            OP_SUB:           alu_y = bus.A - bus.B;
            OP_XOR:           alu_y = bus.A ^ bus.B;
            OP_LUI:           alu_y = {bus.B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLL:           alu_y = bus.A << bus.B[SHW-1:0];
            OP_SRL:           alu_y = bus.A >> bus.B[SHW-1:0];
            default:          alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MULTU) begin
                        state_d = S_MUL;
                    end else if ((bus.op == OP_DIVU) && !md_dbz) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (md_fin) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle ops and divide-by-zero complete on the accept edge; iterative
    // ops complete on the edge where the final iteration is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            dbz_q <= md_dbz;
            if (md_dbz) begin
                result_q <= '1;
                zero_q   <= 1'b0;
                hi_q     <= bus.A;
                lo_q     <= '1;
            end else if (!op_is_iter(bus.op)) begin
                result_q <= alu_y;
                zero_q   <= (alu_y == '0);
            end
        end else if (md_fin) begin
            result_q <= md_lo;
            zero_q   <= (md_lo == '0);
            hi_q     <= md_hi;
            lo_q     <= md_lo;
        end
    end

    assign bus.ready       = (state_q == S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_seq
// Brief    : Directed self-checking bench for alu_seq with a queue scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W   = 32;
    localparam int SHW = $clog2(W);

    typedef struct {
        logic [W-1:0] result;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         zero;
        logic         dbz;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t         sb[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] m_hi     = '0;
    logic [W-1:0] m_lo     = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [2*W-1:0] p;
        e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0; e.lat = 1; e.result = '0;
        case (op)
            OP_AND:          e.result = a & b;
            OP_OR:           e.result = a | b;
            OP_NOR:          e.result = ~(a | b);
            OP_ADD, OP_WORD: e.result = a + b;
            OP_SUB:          e.result = a - b;
            OP_XOR:          e.result = a ^ b;
            OP_LUI:          e.result = {b[W/2-1:0], {(W/2){1'b0}}};
            OP_SLL:          e.result = a << b[SHW-1:0];
            OP_SRL:          e.result = a >> b[SHW-1:0];
            OP_MULTU: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.result = e.lo; e.lat = W + 1;
            end
            OP_DIVU: begin
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.result = '1; e.dbz = 1'b1;
                end else begin
                    e.hi = a % b; e.lo = a / b; e.result = e.lo; e.lat = W + 1;
                end
            end
            default:         e.result = '0;
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    // Drive a request in cycle 0, then scramble inputs in cycle 1.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        check("ready_at_issue", W'(bus.ready), W'(1));
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        e = model(op, a, b);
        sb.push_back(e);
        m_hi = e.hi; m_lo = e.lo;
        @(negedge clk);
        bus.start = 1'b0; bus.op = OP_SUB; bus.A = $urandom(); bus.B = $urandom();
    endtask

    task automatic wait_done(input int cyc0);
        int   cyc;
        int   ready_hits;
        exp_t e;
        cyc = cyc0; ready_hits = 0;
        while (bus.done !== 1'b1 && cyc < 80) begin
            if (bus.ready !== 1'b0) ready_hits++;
            @(negedge clk);
            cyc++;
        end
        if (bus.ready !== 1'b0) ready_hits++;
        e = sb.pop_front();
        check("latency", W'(cyc), W'(e.lat));
        check("ready_low_busy", W'(ready_hits), W'(0));
        check("result", bus.result, e.result);
        check("zero", W'(bus.zero), W'(e.zero));
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_single_pulse", W'(bus.done), W'(0));
        check("ready_after_done", W'(bus.ready), W'(1));
    endtask

    task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b);
        wait_done(1);
        after_done();
    endtask

    initial begin
        int done_seen;
        reset = 1'b1; bus.start = 1'b0; bus.op = OP_AND; bus.A = '0; bus.B = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", W'(bus.ready), W'(1));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_result", bus.result, '0);
        check("rst_zero", W'(bus.zero), W'(0));
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        check("rst_dbz", W'(bus.div_by_zero), W'(0));
        reset = 1'b0;

        run(OP_ADD, 32'd7, 32'd5);
        run(OP_SUB, 32'd5, 32'd5);
        run(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        run(OP_DIVU, 32'd100, 32'd7);
        run(OP_DIVU, 32'd9, 32'd0);
        run(OP_ADD, 32'd1, 32'd1);
        run(OP_SLL, 32'd1, 32'd33);
        run(OP_SRL, 32'h8000_0000, 32'd31);
        run(OP_LUI, 32'hDEAD_BEEF, 32'h0000_1234);
        run(4'b1110, 32'd3, 32'd4);
        for (int i = 0; i < 7; i++) begin
            run(4'(i), $urandom(), $urandom());
        end
        run(OP_DIVU, $urandom(), $urandom_range(1, 65535));

        // Request held high during a MULTU must wait for ready.
        issue(OP_MULTU, $urandom(), $urandom());
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_ADD; bus.A = 32'd30; bus.B = 32'd12;
        begin
            exp_t e;
            e = model(OP_ADD, 32'd30, 32'd12);
            sb.push_back(e);
        end
        wait_done(5);
        after_done();
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(1);
        after_done();

        // Reset in the middle of a divide.
        run(OP_DIVU, 32'd77, 32'd0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.A = 32'd1000; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_reset", W'(bus.ready), W'(0));
        reset = 1'b1;
        #1;
        check("abort_ready", W'(bus.ready), W'(1));
        check("abort_done", W'(bus.done), W'(0));
        check("abort_result", bus.result, '0);
        check("abort_hi", bus.hi, '0);
        check("abort_lo", bus.lo, '0);
        check("abort_dbz", W'(bus.div_by_zero), W'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("no_done_after_abort", W'(done_seen), W'(0));
        run(OP_ADD, 32'd20, 32'd22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath ALU. It executes all single-cycle ALU operations with a registered result and adds iterative unsigned multiply and divide, which write a HI/LO register pair. A start/ready/done handshake lets the control unit stall the pipeline while a long operation runs. It sits in the execute stage alongside the register file.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be even and ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width (localparam, derived).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; accepted only when ready=1.
- op  in  4  operation code (see Operation).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ready  out  1  =1 in IDLE only (combinational from state).
- done  out  1  one-cycle pulse; result/hi/lo/zero/div_by_zero valid.
- result  out  WIDTH  registered result.
- zero  out  1  result==0, registered with result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_by_zero  out  1  set with done when DIVU had B==0; cleared on next accept.

## Operation
- Opcodes: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, XOR 0101, WORD 0110 (=ADD), LUI 0111, SLL 1000, SRL 1001, MULTU 1010, DIVU 1011; 1100–1111 undefined.
- LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}. SLL/SRL: logical shift of A by B[SHW-1:0]; upper B bits ignored.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Undefined op: result=0, zero=1, hi/lo unchanged.
- A, B, op captured on accept (start & ready); later input changes ignored. start while busy is ignored, not queued.
- FSM states IDLE, MUL, DIV, DONE.
  - IDLE→DONE: single-cycle or undefined op, or DIVU with B==0.
  - IDLE→MUL: MULTU. IDLE→DIV: DIVU with B≠0.
  - MUL/DIV→DONE after WIDTH iterations.
  - DONE→IDLE unconditionally.
- MULTU: shift-add, one multiplier bit per cycle; {hi,lo}=A*B (2·WIDTH bits); result=lo.
- DIVU: restoring, one quotient bit per cycle; lo=A/B, hi=A%B; result=lo.
- DIVU with B==0: lo=all ones, hi=A, result=all ones, div_by_zero=1.
- hi/lo change only on MULTU/DIVU completion. Outputs hold until the next completion.

## Timing
- Reset values: state IDLE, ready=1, done=0, result=0, zero=0, hi=0, lo=0, div_by_zero=0.
- Accept in cycle 0:
  - Single-cycle op / div-by-zero: done=1 in cycle 1, ready=1 in cycle 2.
  - MULTU/DIVU: done=1 in cycle WIDTH+1 (33 at WIDTH=32), ready in WIDTH+2.
- Back-to-back: start held high is accepted again in the first cycle ready=1.
- Reset asserted mid-operation aborts immediately: no done, all outputs return to reset values, ready=1 while reset is high.

## Structure
- Package alu_seq_pkg: opcode localparams, FSM state encoding, opcode-is-iterative helper function.
- Sub-module alu_seq_muldiv: iteration counter, partial-product/remainder shift registers, div-by-zero detect. It exposes go/op_div/fin; the top holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- ADD A=7,B=5 -> done at cycle 1, result=12, zero=0. SUB A=5,B=5 -> result=0, zero=1. hi/lo unchanged.
- MULTU A=0xFFFFFFFF,B=2 -> done at cycle 33, hi=0x00000001, lo=result=0xFFFFFFFE, ready=0 cycles 1–33.
- DIVU A=100,B=7 -> done at cycle 33, lo=14, hi=2. DIVU A=9,B=0 -> done at cycle 1, lo=0xFFFFFFFF, hi=9, div_by_zero=1.
- SLL A=1,B=33 -> result=2. LUI B=0x00001234 -> 0x12340000. op=1110 -> result=0, zero=1.
- Issue ADD (start=1) during a MULTU busy window -> ignored; MULTU result correct; ADD accepted only when ready returns.
- Assert reset at cycle 10 of a DIVU -> no done pulse; hi=lo=result=0, ready=1; new ADD accepted after reset deasserts.
